mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential 4x4 signed multiplier between N requesters. It sits between the requester ports and the multiplier. It accepts one operand pair at a time over a valid/ready handshake, issues a single-cycle start pulse to the multiplier, and waits a fixed latency. It then returns the 8-bit product to the winning requester, tagged with that requester's index.

---
 rtl/mult_arbiter_if.sv | 34 +++
 rtl/mult_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// Bundle between the requesters, the shared multiplier and mult_arbiter.
//   req_valid/req_a/req_b  : per-requester request and packed 4-bit operands (slot i at [4i+3:4i])
//   req_ready              : one-hot accept pulse back to the granted requester
//   resp_valid/resp_id/resp_c : one-cycle response pulse, owner index and signed 8-bit product
//   busy                   : arbiter is not idle
//   mult_start/mult_a/mult_b : start pulse and operands towards the multiplier
//   mult_c                 : product from the multiplier
// Modport slave is the arbiter view; master is the requester/multiplier side.
interface mult_arbiter_if #(
  parameter int unsigned N = 4
) ();
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [2:0]     resp_id;
  logic [7:0]     resp_c;
  logic           busy;
  logic           mult_start;
  logic [3:0]     mult_a;
  logic [3:0]     mult_b;
  logic [7:0]     mult_c;

  modport slave (
    input  req_valid, req_a, req_b, mult_c,
    output req_ready, resp_valid, resp_id, resp_c, busy, mult_start, mult_a, mult_b
  );

  modport master (
    output req_valid, req_a, req_b, mult_c,
    input  req_ready, resp_valid, resp_id, resp_c, busy, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential 4x4 signed multiplier among N requesters.
// One operation in flight: accept in IDLE, pulse mult_start in ISSUE, count MULT_LAT cycles in
// WAIT, capture the product, then present it for one cycle in RESP tagged with the owner index.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mult_arbiter_if.slave (requests, responses, multiplier operands/product, busy)
module mult_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MULT_LAT = 10,
  parameter int unsigned CW       = 4
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]    cur_id_q, cur_id_d;
  logic [2:0]    resp_id_q, resp_id_d;
  logic [3:0]    op_a_q, op_a_d;
  logic [3:0]    op_b_q, op_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    resp_c_q, resp_c_d;

  logic          found_hi, found_lo, found;
  logic [2:0]    win_hi, win_lo, win;
  logic [3:0]    sel_a, sel_b;
  logic [N-1:0]  ready;
  logic          drive_ops;

  // Winner search: first valid strictly above rr_ptr, otherwise the lowest valid at or below it,
  // which is the same as an upward search from rr_ptr+1 wrapping at N-1.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (bus.req_valid[j]) begin
        if (3'(j) > rr_ptr_q) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = 3'(j);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = 3'(j);
        end
      end
    end
    found = found_hi | found_lo;
    win   = found_hi ? win_hi : win_lo;
  end

  // Operand mux and one-hot accept. Accept is suppressed while rst is high so a requester never
  // sees a grant for a request the reset edge will discard.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    ready = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (3'(j) == win) begin
        sel_a    = bus.req_a[4*j +: 4];
        sel_b    = bus.req_b[4*j +: 4];
        ready[j] = (state_q == StIdle) && found && !rst;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_id_d  = cur_id_q;
    resp_id_d = resp_id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    cnt_d     = cnt_q;
    resp_c_d  = resp_c_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          rr_ptr_d = win;
          cur_id_d = win;
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CW'(MULT_LAT);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - CW'(1);
        // Counter reaching 1 marks the cycle in which mult_c first holds the product.
        if (cnt_q == CW'(1)) begin
          resp_c_d  = bus.mult_c;
          resp_id_d = cur_id_q;
          state_d   = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= 3'(N - 1);
      cur_id_q  <= '0;
      resp_id_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      cnt_q     <= '0;
      resp_c_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_id_q  <= cur_id_d;
      resp_id_q <= resp_id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_q     <= cnt_d;
      resp_c_q  <= resp_c_d;
    end
  end

  // Outputs decode the registered state only (besides the accept pulse).
  assign drive_ops      = (state_q == StIssue) || (state_q == StWait);
  assign bus.req_ready  = ready;
  assign bus.busy       = (state_q != StIdle);
  assign bus.mult_start = (state_q == StIssue);
  assign bus.mult_a     = drive_ops ? op_a_q : '0;
  assign bus.mult_b     = drive_ops ? op_b_q : '0;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_c     = resp_c_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural fixed-latency multiplier and a
// response scoreboard filled at each accept.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int L = 10;

  typedef struct {
    logic [2:0] id;
    logic [7:0] c;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_arbiter_if #(.N(N)) bus ();

  mult_arbiter #(
    .N(N),
    .MULT_LAT(L),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] ea, eb;
    ea = {{4{a[3]}}, a};
    eb = {{4{b[3]}}, b};
    return 8'(ea * eb);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Multiplier model: product appears MULT_LAT cycles after the start cycle; junk before that.
  logic [3:0] ma, mb;
  int         mk = 0;
  always @(posedge clk) begin
    if (rst) begin
      mk         <= 0;
      bus.mult_c <= 8'h00;
    end else if (bus.mult_start) begin
      ma         <= bus.mult_a;
      mb         <= bus.mult_b;
      mk         <= L - 1;
      bus.mult_c <= 8'h5A;
    end else if (mk != 0) begin
      if (mk == 1) bus.mult_c <= smul(ma, mb);
      mk <= mk - 1;
    end
  end

  // Protocol monitor and scoreboard.
  logic       acc_prev = 1'b0;
  logic       have_op = 1'b0;
  logic       exp_busy;
  int         acc_cyc = 0;
  int         mid;
  logic [3:0] pa = '0, pb = '0;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      have_op  = 1'b0;
      acc_prev = 1'b0;
    end else begin
      exp_busy = have_op && (cyc - acc_cyc >= 1) && (cyc - acc_cyc <= L + 2);
      check("busy", bus.busy, exp_busy);
      check("start_after_accept", bus.mult_start, acc_prev);
      if (bus.mult_start) begin
        check("mult_a", bus.mult_a, pa);
        check("mult_b", bus.mult_b, pb);
      end
      if (!bus.busy) check("idle_ops", {bus.mult_a, bus.mult_b}, 8'h00);
      if (|bus.req_ready) begin
        check("ready_onehot", $onehot(bus.req_ready), 1);
        mid = 0;
        for (int j = 0; j < N; j++) if (bus.req_ready[j]) mid = j;
        pa = bus.req_a[4*mid +: 4];
        pb = bus.req_b[4*mid +: 4];
        sb.push_back('{id: 3'(mid), c: smul(pa, pb), cyc: cyc});
        have_op = 1'b1;
        acc_cyc = cyc;
      end
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("resp_id", bus.resp_id, e.id);
          check("resp_c", bus.resp_c, e.c);
          check("resp_latency", cyc - e.cyc, L + 2);
        end
      end
      acc_prev = |bus.req_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic v);
    bus.req_a[4*i +: 4] = a;
    bus.req_b[4*i +: 4] = b;
    bus.req_valid[i]    = v;
  endtask

  task automatic wait_grant(input int budget, output int id, output int gcyc);
    id   = -1;
    gcyc = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        for (int j = 0; j < N; j++) if (bus.req_ready[j]) id = j;
        gcyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int budget, output int id, output logic [7:0] c);
    id = -1;
    c  = 8'hxx;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        id = int'(bus.resp_id);
        c  = bus.resp_c;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_id"}, bus.resp_id, 0);
    check({tag, "_resp_c"}, bus.resp_c, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_mult_start"}, bus.mult_start, 0);
    check({tag, "_mult_a"}, bus.mult_a, 0);
    check({tag, "_mult_b"}, bus.mult_b, 0);
  endtask

  logic [3:0] ca[4]   = '{4'h8, 4'h8, 4'hF, 4'h0};
  logic [3:0] cb[4]   = '{4'h8, 4'h7, 4'h1, 4'hB};
  logic [7:0] cexp[4] = '{8'h40, 8'hC8, 8'hFF, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         id, gc, pc, seen;
    logic [7:0] rc;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Single request from requester 2.
    tick();
    set_req(2, 4'd3, 4'd5, 1'b1);
    wait_grant(20, id, gc);
    check("single_ready", bus.req_ready, 4'b0100);
    tick();
    set_req(2, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    check("single_start", bus.mult_start, 1);
    check("single_ready_once", bus.req_ready, 0);
    wait_resp(30, id, rc);
    check("single_resp_id", id, 2);
    check("single_resp_c", rc, 8'h0F);
    check("single_resp_cycle", cyc - gc, 12);

    // All four held from reset: grants 0,1,2,3,0 exactly MULT_LAT+3 apart.
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 4'(14 - i), 1'b1);
    tick();
    rst = 1'b0;
    pc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, id, gc);
      check("rr_order", id, k % 4);
      if (k > 0) check("rr_gap", gc - pc, L + 3);
      pc = gc;
    end
    tick();
    bus.req_valid = '0;
    wait_resp(30, id, rc);
    check("rr_last_resp_id", id, 0);

    // Fairness: after 2, pending 1 and 3 -> 3 first; 0 raised during WAIT beats 1.
    tick();
    set_req(2, 4'h2, 4'h6, 1'b1);
    wait_grant(20, id, gc);
    check("fair_first", id, 2);
    tick();
    set_req(2, 4'h0, 4'h0, 1'b0);
    set_req(1, 4'h5, 4'h3, 1'b1);
    set_req(3, 4'hC, 4'h3, 1'b1);
    wait_grant(20, id, gc);
    check("fair_second", id, 3);
    tick();
    set_req(3, 4'h0, 4'h0, 1'b0);
    repeat (3) tick();
    set_req(0, 4'h9, 4'h2, 1'b1);
    wait_grant(20, id, gc);
    check("fair_third", id, 0);
    tick();
    set_req(0, 4'h0, 4'h0, 1'b0);
    wait_grant(20, id, gc);
    check("fair_fourth", id, 1);
    tick();
    set_req(1, 4'h0, 4'h0, 1'b0);
    wait_resp(30, id, rc);
    check("fair_resp_id", id, 1);

    // Signed corner products.
    for (int k = 0; k < 4; k++) begin
      tick();
      set_req(1, ca[k], cb[k], 1'b1);
      wait_grant(20, id, gc);
      check("corner_id", id, 1);
      tick();
      set_req(1, 4'h0, 4'h0, 1'b0);
      wait_resp(30, id, rc);
      check("corner_c", rc, cexp[k]);
    end

    // Reset mid-WAIT (counter 5) aborts requester 0's operation.
    tick();
    set_req(0, 4'h7, 4'h7, 1'b1);
    wait_grant(20, id, gc);
    check("abort_grant", id, 0);
    tick();
    set_req(0, 4'h0, 4'h0, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    tick();
    set_req(1, 4'h3, 4'hD, 1'b1);
    set_req(0, 4'h6, 4'h4, 1'b1);
    wait_grant(20, id, gc);
    check("post_reset_first", id, 0);
    tick();
    set_req(0, 4'h0, 4'h0, 1'b0);
    wait_grant(20, id, gc);
    check("post_reset_second", id, 1);
    tick();
    set_req(1, 4'h0, 4'h0, 1'b0);
    wait_resp(30, id, rc);
    check("post_reset_resp_id", id, 1);

    // Requester 3 pulses valid for one cycle during WAIT: never granted.
    tick();
    set_req(2, 4'hA, 4'h5, 1'b1);
    wait_grant(20, id, gc);
    check("withdraw_owner", id, 2);
    tick();
    set_req(2, 4'h0, 4'h0, 1'b0);
    seen = 0;
    repeat (3) tick();
    set_req(3, 4'h1, 4'h1, 1'b1);
    @(negedge clk);
    if (bus.req_ready[3]) seen++;
    tick();
    set_req(3, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.req_ready[3]) seen++;
    end
    check("withdraw_no_grant", seen, 0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
